// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or above start, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic             found,
  output logic [IW-1:0]    idx
);

  // Scan offsets from farthest to nearest so the nearest set bit wins
  always_comb begin
    int unsigned pos;
    pos   = 32'd0;
    found = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = (32'(start) + 32'(i)) % N_REQ;
      if (req[IW'(pos)]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDLE_TO   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_ready,
  output logic                        fifo_wr_en,
  output logic [WIDTH-1:0]            fifo_data,
  output logic                        grant_active,
  output logic [$clog2(N_REQ)-1:0]    grant_id
);

  localparam int unsigned IW = clog2_min1(N_REQ);
  localparam int unsigned BW = clog2_min1(MAX_BURST + 1);
  localparam int unsigned DW = clog2_min1(IDLE_TO);

  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [DW-1:0] IDLE_LAST = DW'(IDLE_TO - 1);
  localparam logic [IW-1:0] OWNER_MAX = IW'(N_REQ - 1);

  arb_state_e    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick;
  logic [IW-1:0] next_ptr;
  logic [BW-1:0] beat_cnt;
  logic [DW-1:0] idle_cnt;
  logic          found;
  logic          is_grant;
  logic          owner_valid;
  logic          xfer;
  logic          release_now;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req   (req_valid),
    .start (rr_ptr),
    .found (found),
    .idx   (pick)
  );

  assign is_grant    = (state == ARB_GRANT);
  assign owner_valid = req_valid[owner];
  assign xfer        = fifo_wr_en & fifo_ready;
  assign next_ptr    = (owner == OWNER_MAX) ? '0 : owner + 1'b1;

  // Burst ends on last beat, full burst, or owner idle timeout
  assign release_now = is_grant &
                       ((xfer & (req_last[owner] | (beat_cnt == BEAT_LAST))) |
                        (~owner_valid & (idle_cnt == IDLE_LAST)));

  // Write port mux driven from the registered owner
  assign fifo_wr_en   = is_grant & owner_valid;
  assign fifo_data    = req_data[owner];
  assign grant_active = is_grant;
  assign grant_id     = owner;

  // One-hot beat accept toward the current owner only
  always_comb begin
    req_ready = '0;
    if (is_grant && fifo_ready) begin
      req_ready[owner] = 1'b1;
    end
  end

  // Arbitration FSM with rotation pointer and burst/idle counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            state    <= ARB_GRANT;
            owner    <= pick;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        ARB_GRANT: begin
          if (release_now) begin
            state  <= ARB_IDLE;
            rr_ptr <= next_ptr;
          end else begin
            if (xfer) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            if (owner_valid) begin
              idle_cnt <= '0;
            end else if (idle_cnt != IDLE_LAST) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO's write port between N_REQ producers. A granted producer keeps the port for a burst that ends on its `req_last`, at MAX_BURST beats, or after IDLE_TO idle cycles; ownership then rotates. It sits directly in front of the FIFO write side, driving its write enable and data and obeying its `ready`.

## Interface
- `N_REQ`, 4: number of requesters (2..16).
- `WIDTH`, 8: data width; must match the FIFO WIDTH.
- `MAX_BURST`, 4: maximum beats per grant (≥1).
- `IDLE_TO`, 3: consecutive owner-idle cycles that force release (≥1).

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in N_REQ: per-requester write request.
- `req_data` in N_REQ×WIDTH: packed array, one word per requester.
- `req_last` in N_REQ: final beat of the requester's packet.
- `req_ready` out N_REQ: one-hot beat accept.
- `fifo_ready` in 1: FIFO not full.
- `fifo_wr_en` out 1: FIFO write enable.
- `fifo_data` out WIDTH: FIFO write data.
- `grant_active` out 1: a requester owns the port.
- `grant_id` out $clog2(N_REQ): current owner index.

## Operation
- FSM states:
  - ARB_IDLE: no owner. If any `req_valid` is set, pick the first set bit searching from `rr_ptr` upward with wrap-around. Next cycle: ARB_GRANT, `owner`←pick, `beat_cnt`←0, `idle_cnt`←0.
  - ARB_GRANT: `owner` is fixed. The port is released when any one of these holds:
    - a beat transfers with `req_last[owner]` set;
    - a beat transfers with `beat_cnt==MAX_BURST-1`;
    - `idle_cnt==IDLE_TO-1` and `req_valid[owner]` is low.
  - On release: next state ARB_IDLE, `rr_ptr`←(owner+1) mod N_REQ.
- Datapath (combinational from registered `owner`/state):
  - `fifo_wr_en` = GRANT & `req_valid[owner]`.
  - `fifo_data` = `req_data[owner]`.
  - `req_ready[i]` = GRANT & (i==owner) & `fifo_ready`.
- Beat transfer = `fifo_wr_en & fifo_ready`.
- `beat_cnt`:
  - increments on each transfer;
  - width $clog2(MAX_BURST+1);
  - never exceeds MAX_BURST-1, because release fires first.
- `idle_cnt`:
  - increments on GRANT cycles with `req_valid[owner]` low;
  - clears on any owner-valid cycle;
  - saturates at IDLE_TO-1.
- `fifo_ready` low stalls a transfer. Stall cycles count neither beats nor idle, and the grant is held.
- Non-owner `req_valid`, `req_data` and `req_last` are ignored; requesters must hold data until `req_ready`.
- `grant_active` = (state==GRANT); `grant_id` = `owner` (value in IDLE = last owner).

## Timing
- Reset values: state ARB_IDLE, `rr_ptr`=0, `owner`=0, counters 0. Outputs: `fifo_wr_en`=0, `req_ready`=0, `grant_active`=0, `grant_id`=0.
- Arbitration latency: 1 cycle. A request seen in IDLE at cycle t gives a grant and possible first beat at t+1.
- Every release costs one IDLE bubble, so peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- `req_last` with `beat_cnt==MAX_BURST-1` in the same transfer: a single release, pointer advances once.
- A single active requester is re-granted after each bubble (rotation falls back to it).
- `rst` mid-burst: state returns to reset values on the next edge, and no `fifo_wr_en` is asserted in that cycle's response. Words already in the FIFO are untouched.
- `fifo_ready` low for the entire grant: the owner holds indefinitely (no timeout on back-pressure).

## Structure
- Package `fifo_arb_pkg`:
  - typedef `arb_state_e` {ARB_IDLE, ARB_GRANT};
  - function `clog2_min1` for index widths.
- Sub-module `rr_picker`: combinational. Inputs are a request vector and a start pointer; outputs are `found` and the picked index, searched with wrap-around. Instantiated once.
- Top holds the FSM, `rr_ptr`, `owner`, both counters and the output mux.

## Test plan
- Reset, then `req_valid`=4'b1111 held with `req_last`=0 → grants in order 0,1,2,3,0; each grant is exactly 4 beats followed by 1 bubble cycle.
- Only requester 2 valid, `req_last` on beat 2 → grant 2 for 2 beats, IDLE 1 cycle, re-grant 2; `rr_ptr`=3 after the release.
- Owner 1 drops `req_valid` for 3 cycles mid-burst while requester 3 waits → release after the 3rd idle cycle; next grant 3.
- `fifo_ready` low for 5 cycles during the owner's 2nd beat → `req_ready` low, `beat_cnt` frozen at 1, no timeout; burst completes after `fifo_ready` rises.
- `rst` pulsed for 1 cycle in the 3rd beat of requester 1 → next cycle all outputs 0; with all requesters valid, next grant is 0.
- `req_last` on the 4th beat (MAX_BURST=4) → one release, `rr_ptr` advances by exactly 1.
